// File: rtl/cfu_conv_preload_mac_pkg.sv
// rtl/cfu_conv_preload_mac_pkg.sv - shared opcode/state types and status bit positions
// Purpose: opcodes (function_id[9:3]), FSM states and status register bit indices
//          used by cfu_conv_preload_mac.
package cfu_conv_pkg;

  typedef enum logic [6:0] {
    OP_MAC     = 7'd0,
    OP_CLEAR   = 7'd1,
    OP_CONFIG  = 7'd2,
    OP_PRELOAD = 7'd3,
    OP_STATUS  = 7'd4
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_FETCH,
    ST_MAC,
    ST_RSP
  } state_e;

  // status[0]: a bus error ended the last fetch/preload
  // status[1]: a MAC asked for a filter word beyond the loaded count
  localparam int STATUS_BUS_ERR = 0;
  localparam int STATUS_IDX_OOR = 1;

endpackage

// File: rtl/cfu_conv_preload_mac_simd_mac_lane_sum.sv
// rtl/cfu_conv_preload_mac_simd_mac_lane_sum.sv - combinational SIMD dot product of one image/filter word pair
// Purpose: sum over lanes of (sext(img)+sext(offset)) * sext(filt), masked per lane.
// Ports:   img_i/filt_i    32-bit packed lane words, lane i at [i*LANE_W +: LANE_W]
//          offset_i        signed LANE_W+1 input offset
//          lane_mask_i     per-lane enable; disabled lanes contribute 0
//          sum_o           signed sum of lane products
module simd_mac_lane_sum #(
  parameter int LANE_W = 8,
  parameter int LANES  = 32 / LANE_W,
  parameter int SUM_W  = 2 * LANE_W + 3
) (
  input  logic [31:0]              img_i,
  input  logic [31:0]              filt_i,
  input  logic signed [LANE_W:0]   offset_i,
  input  logic [LANES-1:0]         lane_mask_i,
  output logic signed [SUM_W-1:0]  sum_o
);

  localparam int PROD_W = 2 * LANE_W + 1;

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [LANE_W:0]   img_off;
    logic signed [LANE_W-1:0] filt;

    // The offset-adjusted image operand is kept LANE_W+1 bits wide, so it
    // wraps exactly like the narrow datapath it models.
    assign img_off = $signed({img_i[gi*LANE_W+LANE_W-1], img_i[gi*LANE_W +: LANE_W]}) + offset_i;
    assign filt    = $signed(filt_i[gi*LANE_W +: LANE_W]);
    assign prod[gi] = lane_mask_i[gi] ? (PROD_W'(img_off) * PROD_W'(filt)) : '0;
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_o = sum_o + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/cfu_conv_preload_mac.sv
// rtl/cfu_conv_preload_mac.sv - CFU that preloads a filter over Wishbone and runs SIMD MACs against it
// Purpose: command/response CFU; PRELOAD bursts filter words into a local buffer,
//          MAC fetches one image word and accumulates a SIMD dot product.
// Ports:   clk, reset_n (async, active-low)
//          cmd_*  CPU command handshake (function_id[9:3] = opcode, two 32-bit operands)
//          rsp_*  CPU response handshake, payload held until rsp_ready
//          cfu_ram_*  Wishbone read-only master (word address, classic cycles)
module cfu_conv_preload_mac
  import cfu_conv_pkg::*;
#(
  parameter int LANE_W       = 8,
  parameter int FILTER_DEPTH = 64,
  parameter int ACC_W        = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [29:0] cfu_ram_adr,
  output logic [31:0] cfu_ram_dat_mosi,
  output logic [3:0]  cfu_ram_sel,
  output logic        cfu_ram_cyc,
  output logic        cfu_ram_stb,
  output logic        cfu_ram_we,
  output logic [2:0]  cfu_ram_cti,
  output logic [1:0]  cfu_ram_bte,
  input  logic [31:0] cfu_ram_dat_miso,
  input  logic        cfu_ram_ack,
  input  logic        cfu_ram_err
);

  localparam int LANES = 32 / LANE_W;
  localparam int IDX_W = $clog2(FILTER_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int SUM_W = 2 * LANE_W + 3;

  state_e                  state_q;
  logic [ACC_W-1:0]        acc_q;
  logic signed [LANE_W:0]  offset_q;
  logic [LANES-1:0]        lane_mask_q;
  logic [CNT_W-1:0]        loaded_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        n_q;
  logic [1:0]              status_q;
  logic [31:0]             rsp_q;
  logic [31:0]             img_q;
  logic [29:0]             adr_q;
  logic                    cyc_q;
  logic                    stb_q;
  logic [IDX_W-1:0]        idx_q;

  logic [31:0] filt_mem [FILTER_DEPTH];

  opcode_e                 opcode;
  logic                    idx_ok;
  logic [CNT_W-1:0]        n_clamped;
  logic [CNT_W-1:0]        cnt_inc;
  logic [7:0]              loaded_lo;
  logic [31:0]             filt_word;
  logic signed [SUM_W-1:0] lane_sum;
  logic [ACC_W-1:0]        acc_nxt;
  logic                    unused_fid;

  assign opcode     = opcode_e'(cmd_payload_function_id[9:3]);
  assign unused_fid = ^cmd_payload_function_id[2:0];
  assign idx_ok     = cmd_payload_inputs_1 < 32'(loaded_q);
  assign n_clamped  = (cmd_payload_inputs_1 > 32'(FILTER_DEPTH)) ? CNT_W'(FILTER_DEPTH)
                                                                 : cmd_payload_inputs_1[CNT_W-1:0];
  assign cnt_inc    = cnt_q + 1'b1;
  assign loaded_lo  = 8'(loaded_q);
  assign filt_word  = filt_mem[idx_q];
  assign acc_nxt    = acc_q + ACC_W'(lane_sum);

  simd_mac_lane_sum #(
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .SUM_W  (SUM_W)
  ) u_lane_sum (
    .img_i       (img_q),
    .filt_i      (filt_word),
    .offset_i    (offset_q),
    .lane_mask_i (lane_mask_q),
    .sum_o       (lane_sum)
  );

  // Filter buffer: not reset; an erroring beat is never stored.
  always_ff @(posedge clk) begin
    if (state_q == ST_PRELOAD && stb_q && cfu_ram_ack && !cfu_ram_err) begin
      filt_mem[cnt_q[IDX_W-1:0]] <= cfu_ram_dat_miso;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      offset_q    <= '0;
      lane_mask_q <= '1;
      loaded_q    <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      status_q    <= '0;
      rsp_q       <= '0;
      img_q       <= '0;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (opcode)
              OP_MAC: begin
                if (idx_ok) begin
                  adr_q   <= cmd_payload_inputs_0[31:2];
                  idx_q   <= cmd_payload_inputs_1[IDX_W-1:0];
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  state_q <= ST_FETCH;
                end else begin
                  status_q[STATUS_IDX_OOR] <= 1'b1;
                  rsp_q   <= acc_q[31:0];
                  state_q <= ST_RSP;
                end
              end
              OP_CLEAR: begin
                acc_q    <= '0;
                status_q <= '0;
                rsp_q    <= '0;
                state_q  <= ST_RSP;
              end
              OP_CONFIG: begin
                offset_q    <= cmd_payload_inputs_0[LANE_W:0];
                lane_mask_q <= cmd_payload_inputs_1[LANES-1:0];
                rsp_q       <= '0;
                state_q     <= ST_RSP;
              end
              OP_PRELOAD: begin
                loaded_q <= '0;
                if (n_clamped == '0) begin
                  rsp_q   <= '0;
                  state_q <= ST_RSP;
                end else begin
                  adr_q   <= cmd_payload_inputs_0[31:2];
                  n_q     <= n_clamped;
                  cnt_q   <= '0;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  state_q <= ST_PRELOAD;
                end
              end
              OP_STATUS: begin
                rsp_q   <= {16'b0, loaded_lo, 6'b0, status_q};
                state_q <= ST_RSP;
              end
              default: begin
                rsp_q   <= 32'hFFFF_FFFF;
                state_q <= ST_RSP;
              end
            endcase
          end
        end
        ST_FETCH: begin
          // err is checked first so a simultaneous ack is discarded
          if (cfu_ram_err) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            status_q[STATUS_BUS_ERR] <= 1'b1;
            rsp_q    <= acc_q[31:0];
            state_q  <= ST_RSP;
          end else if (cfu_ram_ack) begin
            img_q   <= cfu_ram_dat_miso;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q   <= acc_nxt;
          rsp_q   <= acc_nxt[31:0];
          state_q <= ST_RSP;
        end
        ST_PRELOAD: begin
          if (cfu_ram_err) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            status_q[STATUS_BUS_ERR] <= 1'b1;
            loaded_q <= cnt_q;
            rsp_q    <= 32'(cnt_q);
            state_q  <= ST_RSP;
          end else if (cfu_ram_ack) begin
            cnt_q <= cnt_inc;
            adr_q <= adr_q + 30'd1;
            // cyc stays high between beats; only the last ack closes the burst
            if (cnt_inc == n_q) begin
              cyc_q    <= 1'b0;
              stb_q    <= 1'b0;
              loaded_q <= n_q;
              rsp_q    <= 32'(n_q);
              state_q  <= ST_RSP;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready             = (state_q == ST_IDLE);
  assign rsp_valid             = (state_q == ST_RSP);
  assign rsp_payload_outputs_0 = rsp_q;
  assign cfu_ram_adr           = adr_q;
  assign cfu_ram_cyc           = cyc_q;
  assign cfu_ram_stb           = stb_q;
  assign cfu_ram_dat_mosi      = '0;
  assign cfu_ram_sel           = 4'b1111;
  assign cfu_ram_we            = 1'b0;
  assign cfu_ram_cti           = '0;
  assign cfu_ram_bte           = '0;

endmodule

// File: tb/tb_cfu_conv_preload_mac.sv
// tb/tb_cfu_conv_preload_mac.sv - scoreboard bench with Wishbone RAM responder and lane-sum reference model
module tb_cfu_conv_preload_mac;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic [29:0] cfu_ram_adr;
  logic [31:0] cfu_ram_dat_mosi;
  logic [3:0]  cfu_ram_sel;
  logic        cfu_ram_cyc;
  logic        cfu_ram_stb;
  logic        cfu_ram_we;
  logic [2:0]  cfu_ram_cti;
  logic [1:0]  cfu_ram_bte;
  logic [31:0] cfu_ram_dat_miso;
  logic        cfu_ram_ack;
  logic        cfu_ram_err;

  always #5 clk = ~clk;

  cfu_conv_preload_mac dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .cfu_ram_adr             (cfu_ram_adr),
    .cfu_ram_dat_mosi        (cfu_ram_dat_mosi),
    .cfu_ram_sel             (cfu_ram_sel),
    .cfu_ram_cyc             (cfu_ram_cyc),
    .cfu_ram_stb             (cfu_ram_stb),
    .cfu_ram_we              (cfu_ram_we),
    .cfu_ram_cti             (cfu_ram_cti),
    .cfu_ram_bte             (cfu_ram_bte),
    .cfu_ram_dat_miso        (cfu_ram_dat_miso),
    .cfu_ram_ack             (cfu_ram_ack),
    .cfu_ram_err             (cfu_ram_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ram [1024];
  int          waits = 0;
  int          err_at = -1;
  int          xfer = 0;
  int          cyc_rises = 0;
  logic [29:0] adr_log[$];

  // reference model state
  logic [31:0] m_acc;
  int          m_off;
  logic [3:0]  m_mask;
  int          m_loaded;
  logic [1:0]  m_status;
  logic [31:0] m_buf [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wishbone RAM responder: ack after `waits` idle cycles per beat, optional err on beat err_at
  initial begin : responder
    int   wcnt;
    bit   err_last;
    logic cyc_prev;
    wcnt = 0; err_last = 0; cyc_prev = 1'b0;
    cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0; cfu_ram_dat_miso = '0;
    forever begin
      @(negedge clk);
      if (err_last) check("cyc_drop_after_err", 32'({cfu_ram_cyc, cfu_ram_stb}), 32'd0);
      err_last = 0;
      cfu_ram_ack = 1'b0;
      cfu_ram_err = 1'b0;
      if (cfu_ram_cyc && !cyc_prev) cyc_rises++;
      cyc_prev = cfu_ram_cyc;
      if (cfu_ram_cyc && cfu_ram_stb) begin
        if (wcnt >= waits) begin
          wcnt = 0;
          if (xfer == err_at) begin
            cfu_ram_err = 1'b1;
            cfu_ram_ack = 1'($urandom_range(0, 1));
            err_last = 1;
          end else begin
            cfu_ram_ack = 1'b1;
            cfu_ram_dat_miso = ram[cfu_ram_adr[9:0]];
            adr_log.push_back(cfu_ram_adr);
          end
          xfer++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Response monitor with random back-pressure
  initial begin : monitor
    logic r;
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      r = ($urandom_range(0, 3) != 0);
      rsp_ready = r;
      if (rsp_valid && r) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%h required=none", rsp_payload_outputs_0);
        end else begin
          e = exp_q.pop_front();
          check(e.name, rsp_payload_outputs_0, e.data);
        end
      end
    end
  end

  task automatic send(input logic [6:0] op, input logic [31:0] a0, input logic [31:0] a1,
                      input string name, input logic [31:0] exp, input bit push = 1);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_payload_function_id = {op, 3'($urandom)};
    cmd_payload_inputs_0    = a0;
    cmd_payload_inputs_1    = a1;
    cmd_valid               = 1'b1;
    while (!cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout actual=cmd_ready_low required=accepted", name);
      cmd_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back('{name, exp});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || !cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic int sbyte(input logic [31:0] w, input int i);
    int v;
    v = int'(w[i*8 +: 8]);
    if (v > 127) v -= 256;
    return v;
  endfunction

  // per lane: ((img + offset) wrapped to 9-bit signed) * filt, masked lanes give 0
  function automatic int lane_sum_ref(input logic [31:0] img, input logic [31:0] filt,
                                      input int off, input logic [3:0] mask);
    int s;
    int a;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a = (sbyte(img, i) + off) & 511;
      if (a > 255) a -= 512;
      if (mask[i]) s += a * sbyte(filt, i);
    end
    return s;
  endfunction

  task automatic m_clear();
    m_acc = '0;
    m_status = '0;
    send(7'd1, $urandom, $urandom, "clear", 32'd0);
  endtask

  task automatic m_config(input logic [31:0] a0, input logic [31:0] a1);
    int o;
    o = int'(a0[8:0]);
    m_off = (o > 255) ? o - 512 : o;
    m_mask = a1[3:0];
    send(7'd2, a0, a1, "config", 32'd0);
  endtask

  task automatic m_preload(input logic [31:0] base, input int n);
    int nn;
    nn = (n > 64) ? 64 : n;
    for (int k = 0; k < nn; k++) m_buf[k] = ram[(int'(base[11:2]) + k) % 1024];
    m_loaded = nn;
    send(7'd3, base, 32'(n), "preload", 32'(nn));
  endtask

  task automatic m_mac(input logic [31:0] img_adr, input int idx);
    if (idx >= m_loaded) begin
      m_status[1] = 1'b1;
      send(7'd0, img_adr, 32'(idx), "mac_oor", m_acc);
    end else begin
      m_acc = m_acc + 32'(lane_sum_ref(ram[img_adr[11:2]], m_buf[idx], m_off, m_mask));
      send(7'd0, img_adr, 32'(idx), "mac", m_acc);
    end
  endtask

  task automatic m_status_cmd();
    send(7'd4, $urandom, $urandom, "status", {16'b0, 8'(m_loaded), 6'b0, m_status});
  endtask

  initial begin : stimulus
    int r0;
    cmd_valid = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    ram[10'h40] = 32'h0102_0304;
    ram[10'h41] = 32'hFF01_0203;
    ram[10'h42] = 32'h1122_3344;
    ram[10'h43] = 32'h5566_7788;
    ram[10'h80] = 32'h8080_8080;
    ram[10'h81] = 32'h7F7F_7F7F;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus", 32'({cfu_ram_cyc, cfu_ram_stb, rsp_valid, cmd_ready}), 32'b0001);
    check("tied_outputs", 32'({cfu_ram_dat_mosi != 0, cfu_ram_sel, cfu_ram_we, cfu_ram_cti, cfu_ram_bte}),
          32'({1'b0, 4'hF, 1'b0, 3'b0, 2'b0}));
    @(negedge clk);
    reset_n = 1'b1;

    send(7'd4, 32'd0, 32'd0, "status_reset", 32'd0);
    send(7'd9, $urandom, $urandom, "bad_opcode", 32'hFFFF_FFFF);
    drain();
    check("cyc_idle", 32'(cfu_ram_cyc), 32'd0);

    // 4-word preload, two wait states per beat
    waits = 2;
    r0 = cyc_rises;
    adr_log.delete();
    send(7'd3, 32'h100, 32'd4, "preload4", 32'd4);
    drain();
    check("preload4_beats", 32'(adr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < adr_log.size(); i++) check("preload4_adr", 32'(adr_log[i]), 32'h40 + 32'(i));
    check("preload4_single_cyc", 32'(cyc_rises - r0), 32'd1);
    send(7'd4, 32'd0, 32'd0, "status_loaded4", 32'h0000_0400);

    // offset cancels the image value in every lane
    send(7'd2, 32'd128, 32'hF, "config_128", 32'd0);
    send(7'd1, 32'd0, 32'd0, "clear", 32'd0);
    send(7'd0, 32'h200, 32'd0, "mac_zero", 32'd0);
    send(7'd0, 32'h204, 32'd1, "mac_1275", 32'd1275);
    send(7'd1, 32'd0, 32'd0, "clear", 32'd0);
    send(7'd2, 32'd128, 32'h1, "config_mask1", 32'd0);
    send(7'd0, 32'h204, 32'd1, "mac_765", 32'd765);
    drain();

    r0 = cyc_rises;
    send(7'd0, 32'h204, 32'd10, "mac_idx_oor", 32'd765);
    send(7'd4, 32'd0, 32'd0, "status_oor", 32'h0000_0402);
    drain();
    check("oor_no_cyc", 32'(cyc_rises - r0), 32'd0);

    // preload aborted by a bus error on the third beat
    send(7'd1, 32'd0, 32'd0, "clear", 32'd0);
    drain();
    xfer = 0;
    err_at = 2;
    send(7'd3, 32'h300, 32'd8, "preload_err", 32'd2);
    send(7'd4, 32'd0, 32'd0, "status_err", 32'h0000_0201);
    drain();
    err_at = -1;

    // randomized phase against the reference model
    waits = 0;
    m_clear();
    m_config($urandom, $urandom);
    m_preload($urandom, 1000);
    m_mac($urandom, 63);
    m_mac($urandom, 64);
    m_status_cmd();
    for (int it = 0; it < 8; it++) begin
      drain();
      waits = $urandom_range(0, 2);
      m_config($urandom, $urandom);
      if (it == 3) begin
        drain();
        r0 = cyc_rises;
        m_preload($urandom, 0);
        drain();
        check("preload0_no_cyc", 32'(cyc_rises - r0), 32'd0);
      end else begin
        m_preload($urandom, $urandom_range(1, 6));
      end
      for (int j = 0; j < 5; j++) m_mac($urandom, $urandom_range(0, m_loaded + 1));
      m_status_cmd();
      if (it == 5) m_clear();
    end
    drain();

    // reset while a fetch is waiting for ack
    m_preload($urandom, 4);
    drain();
    waits = 100000;
    send(7'd0, $urandom, 32'd0, "mac_hung", 32'd0, 0);
    repeat (3) @(posedge clk);
    #1 check("fetch_cyc_high", 32'({cfu_ram_cyc, cfu_ram_stb}), 32'b11);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_drops_bus", 32'({cfu_ram_cyc, cfu_ram_stb}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    waits = 0;
    send(7'd4, 32'd0, 32'd0, "status_after_reset", 32'd0);
    send(7'd0, 32'h204, 32'd0, "mac_after_reset", 32'd0);
    send(7'd4, 32'd0, 32'd0, "status_after_reset_oor", 32'h0000_0002);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
